watch_mode_controller: RTL and testbench
========================================

WATCH_MODE_CONTROLLER -- requirements
Module: watch_mode_controller

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset; all state SHALL update on the rising edge of clockSignal.
REQ-002 Parameter LAP_DEPTH, default 10: number of lap slots in the stopwatch datapath.
REQ-003 Parameter RING_TICKS, default 3000: number of tick100Hz pulses after which ringSound self-clears (30 s).
REQ-004 clockSignal  in  1  system clock.
REQ-005 resetSignal  in  1  synchronous active-high reset.
REQ-006 modeInput / startOrStop / splitOrReset  in  1 each  button levels, already synchronised and debounced.
REQ-007 tick100Hz  in  1  one-cycle enable pulse at 100 Hz.
REQ-008 timerDone  in  1  countdown datapath reached zero (level).
REQ-009 stopwatchWrap  in  1  one-cycle pulse: stopwatch count passed 24 h.
REQ-010 mode  out  2  00 timer, 01 stopwatch, 10 viewClockAndDate, 11 setAlarm.
REQ-011 timerLoad / timerClear  out  1 each  one-cycle strobes to the countdown datapath.
REQ-012 timerRun  out  1  countdown enable level.
REQ-013 stopwatchRun  out  1  stopwatch enable level.
REQ-014 stopwatchClear / lapStrobe  out  1 each  one-cycle strobes.
REQ-015 lapIndex  out  4  slot written by the current lapStrobe.
REQ-016 lapFull  out  1  all LAP_DEPTH slots used.
REQ-017 ringSound  out  1  alarm sounder enable.

Function
REQ-018 Each button SHALL be edge-detected against its value from the previous cycle; all strobes and state changes SHALL appear in the cycle after the first high sample (1-cycle latency, registered outputs).
REQ-019 When more than one button edge occurs in the same cycle, the priority SHALL be modeInput > splitOrReset > startOrStop; lower-priority edges are discarded.
REQ-020 A modeInput edge SHALL advance mode by 1, modulo 4 (11 -> 00); the timer and stopwatch FSMs SHALL keep running across mode changes.
REQ-021 startOrStop and splitOrReset SHALL act only on the FSM of the current mode; in modes 10 and 11 they SHALL be ignored, except for ring acknowledge (REQ-026).
REQ-022 Timer FSM states SHALL be T_IDLE, T_RUN, T_PAUSE, T_RING: T_IDLE+start -> T_RUN with timerLoad pulse; T_RUN+start -> T_PAUSE; T_PAUSE+start -> T_RUN (no load); T_RUN+timerDone -> T_RING; any state+split -> T_IDLE with timerClear pulse.
REQ-023 timerRun SHALL be 1 only in T_RUN.
REQ-024 Stopwatch FSM states SHALL be S_CLEAR, S_RUN, S_STOP: start toggles S_CLEAR/S_STOP -> S_RUN and S_RUN -> S_STOP; split in S_RUN issues lapStrobe; split in S_STOP -> S_CLEAR with stopwatchClear pulse, lapIndex := 0, lapFull := 0; split in S_CLEAR is ignored.
REQ-025 lapStrobe SHALL carry the current lapIndex, which then increments; after slot LAP_DEPTH-1 is written, lapFull SHALL be set, and further splits in S_RUN SHALL produce no lapStrobe and SHALL leave lapIndex unchanged.
REQ-026 In T_RING, ringSound SHALL be 1; any button edge in any mode SHALL acknowledge it (-> T_IDLE, ringSound 0, timerClear pulse), and that edge SHALL have no other effect, including on mode.
REQ-027 In T_RING, the ring counter SHALL count tick100Hz pulses; on reaching RING_TICKS the FSM SHALL auto-return to T_IDLE with a timerClear pulse.
REQ-028 stopwatchWrap SHALL force S_RUN -> S_CLEAR with a stopwatchClear pulse; it SHALL take precedence over a same-cycle button edge.
REQ-029 timerDone outside T_RUN SHALL be ignored.

Reset
REQ-030 On resetSignal, the block SHALL set mode=00, T_IDLE, S_CLEAR, lapIndex=0, lapFull=0, ring counter=0 and all outputs 0, and SHALL clear the edge-detect history to the current button levels, so that held buttons do not fire.
REQ-031 Reset SHALL override all inputs in the same cycle, including mid-ring and mid-run.

Structure
REQ-032 The mode encodings, timer/stopwatch state encodings, LAP_DEPTH and RING_TICKS defaults SHALL live in shared package watch_pkg, which the datapath also uses.
REQ-033 The three button edge detectors SHALL be one instantiated sub-module, button_edge, replicated three times; the FSMs SHALL stay in this module.

Verification
REQ-034 Scenario: reset, then 5 modeInput pulses -> mode sequence 01,10,11,00,01; no strobes.
REQ-035 Scenario: mode 00, start -> timerLoad for 1 cycle, timerRun=1; start -> timerRun=0; start -> timerRun=1 with no timerLoad; raise timerDone -> ringSound=1 next cycle.
REQ-036 Scenario: ringing, 2999 tick100Hz pulses -> ringSound still 1; 3000th -> ringSound=0 and timerClear pulse; a repeat run acknowledged by modeInput -> ringSound=0 and mode unchanged.
REQ-037 Scenario: mode 01, start, then 11 splits -> lapStrobe with lapIndex 0..9, lapFull=1, 11th split gives no strobe; start, split -> stopwatchClear, lapIndex=0, lapFull=0.
REQ-038 Scenario: modeInput and startOrStop rise in the same cycle in mode 00 -> mode=01, timer stays T_IDLE; stopwatchWrap coincident with split in S_RUN -> S_CLEAR, no lapStrobe.
REQ-039 Scenario: resetSignal asserted in T_RUN with startOrStop held high -> all outputs 0, and no timerLoad after reset is released.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared encodings and defaults for the watch controller and its datapath.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_TIMER      = 2'b00,
    MODE_STOPWATCH  = 2'b01,
    MODE_VIEW_CLOCK = 2'b10,
    MODE_SET_ALARM  = 2'b11
  } modeType;

  typedef enum logic [1:0] {
    T_IDLE  = 2'b00,
    T_RUN   = 2'b01,
    T_PAUSE = 2'b10,
    T_RING  = 2'b11
  } timerStateType;

  typedef enum logic [1:0] {
    S_CLEAR = 2'b00,
    S_RUN   = 2'b01,
    S_STOP  = 2'b10
  } stopwatchStateType;

  localparam int unsigned LAP_DEPTH_DEFAULT  = 10;
  localparam int unsigned RING_TICKS_DEFAULT = 3000;
  localparam int unsigned LAP_INDEX_WIDTH    = 4;

  function automatic modeType nextMode(input modeType current);
    logic [1:0] raw;
    raw = current;
    raw = raw + 2'd1;
    return modeType'(raw);
  endfunction

endpackage

// File: rtl/watch_mode_controller_if.sv
// Button/tick inputs and datapath control outputs of the watch mode controller.
interface watch_mode_controller_if;
  logic       modeInput;
  logic       startOrStop;
  logic       splitOrReset;
  logic       tick100Hz;
  logic       timerDone;
  logic       stopwatchWrap;
  logic [1:0] mode;
  logic       timerLoad;
  logic       timerClear;
  logic       timerRun;
  logic       stopwatchRun;
  logic       stopwatchClear;
  logic       lapStrobe;
  logic [3:0] lapIndex;
  logic       lapFull;
  logic       ringSound;

  modport master (
    output modeInput, startOrStop, splitOrReset, tick100Hz, timerDone, stopwatchWrap,
    input  mode, timerLoad, timerClear, timerRun, stopwatchRun, stopwatchClear,
           lapStrobe, lapIndex, lapFull, ringSound
  );

  modport slave (
    input  modeInput, startOrStop, splitOrReset, tick100Hz, timerDone, stopwatchWrap,
    output mode, timerLoad, timerClear, timerRun, stopwatchRun, stopwatchClear,
           lapStrobe, lapIndex, lapFull, ringSound
  );
endinterface

// File: rtl/button_edge.sv
// Rising-edge detector for one debounced button level.
module button_edge (
  input  logic clockSignal,
  input  logic resetSignal,
  input  logic buttonLevel,
  output logic buttonRise
);

  logic previousLevel;

  // History always tracks the live level, so a button held through reset
  // is already "seen" when reset drops and cannot fire.
  always_ff @(posedge clockSignal) begin
    previousLevel <= buttonLevel;
  end

  assign buttonRise = buttonLevel & ~previousLevel & ~resetSignal;

endmodule

// File: rtl/watch_mode_controller.sv
// Mode selection, countdown timer FSM and stopwatch/lap FSM for the watch.
module watch_mode_controller
  import watch_pkg::*;
#(
  parameter int unsigned LAP_DEPTH  = LAP_DEPTH_DEFAULT,
  parameter int unsigned RING_TICKS = RING_TICKS_DEFAULT
) (
  input logic                    clockSignal,
  input logic                    resetSignal,
  watch_mode_controller_if.slave watchBus
);

  localparam int unsigned RING_WIDTH = $clog2(RING_TICKS + 1);
  localparam logic [RING_WIDTH-1:0] RING_LAST = RING_WIDTH'(RING_TICKS - 1);
  localparam logic [LAP_INDEX_WIDTH-1:0] LAP_LAST = LAP_INDEX_WIDTH'(LAP_DEPTH - 1);

  logic modeRise, startRise, splitRise;

  button_edge modeEdge (
    .clockSignal (clockSignal),
    .resetSignal (resetSignal),
    .buttonLevel (watchBus.modeInput),
    .buttonRise  (modeRise)
  );

  button_edge startEdge (
    .clockSignal (clockSignal),
    .resetSignal (resetSignal),
    .buttonLevel (watchBus.startOrStop),
    .buttonRise  (startRise)
  );

  button_edge splitEdge (
    .clockSignal (clockSignal),
    .resetSignal (resetSignal),
    .buttonLevel (watchBus.splitOrReset),
    .buttonRise  (splitRise)
  );

  modeType                    modeReg, modeNext;
  timerStateType              timerState, timerNext;
  stopwatchStateType          swState, swNext;
  logic [RING_WIDTH-1:0]      ringCount, ringNext;
  logic [LAP_INDEX_WIDTH-1:0] nextSlot, nextSlotNext;
  logic [LAP_INDEX_WIDTH-1:0] lapIndexReg, lapIndexNext;
  logic                       lapFullReg, lapFullNext;
  logic                       timerLoadReg, timerLoadNext;
  logic                       timerClearReg, timerClearNext;
  logic                       swClearReg, swClearNext;
  logic                       lapStrobeReg, lapStrobeNext;

  logic anyRise, acknowledge, modeAct, splitAct, startAct;
  logic timerSplit, timerStart, swSplit, swStart;

  // A ringing alarm swallows every button edge; otherwise only the
  // highest-priority edge survives.
  assign anyRise     = modeRise | startRise | splitRise;
  assign acknowledge = (timerState == T_RING) & anyRise;
  assign modeAct     = modeRise & ~acknowledge;
  assign splitAct    = splitRise & ~modeRise & ~acknowledge;
  assign startAct    = startRise & ~modeRise & ~splitRise & ~acknowledge;
  assign timerSplit  = splitAct & (modeReg == MODE_TIMER);
  assign timerStart  = startAct & (modeReg == MODE_TIMER);
  assign swSplit     = splitAct & (modeReg == MODE_STOPWATCH);
  assign swStart     = startAct & (modeReg == MODE_STOPWATCH);

  always_ff @(posedge clockSignal) begin
    if (resetSignal) begin
      modeReg       <= MODE_TIMER;
      timerState    <= T_IDLE;
      swState       <= S_CLEAR;
      ringCount     <= '0;
      nextSlot      <= '0;
      lapIndexReg   <= '0;
      lapFullReg    <= 1'b0;
      timerLoadReg  <= 1'b0;
      timerClearReg <= 1'b0;
      swClearReg    <= 1'b0;
      lapStrobeReg  <= 1'b0;
    end else begin
      modeReg       <= modeNext;
      timerState    <= timerNext;
      swState       <= swNext;
      ringCount     <= ringNext;
      nextSlot      <= nextSlotNext;
      lapIndexReg   <= lapIndexNext;
      lapFullReg    <= lapFullNext;
      timerLoadReg  <= timerLoadNext;
      timerClearReg <= timerClearNext;
      swClearReg    <= swClearNext;
      lapStrobeReg  <= lapStrobeNext;
    end
  end

  always_comb begin
    modeNext       = modeReg;
    timerNext      = timerState;
    swNext         = swState;
    ringNext       = ringCount;
    nextSlotNext   = nextSlot;
    lapIndexNext   = lapIndexReg;
    lapFullNext    = lapFullReg;
    timerLoadNext  = 1'b0;
    timerClearNext = 1'b0;
    swClearNext    = 1'b0;
    lapStrobeNext  = 1'b0;

    if (modeAct) begin
      modeNext = nextMode(modeReg);
    end

    if (acknowledge) begin
      timerNext      = T_IDLE;
      ringNext       = '0;
      timerClearNext = 1'b1;
    end else if (timerSplit) begin
      timerNext      = T_IDLE;
      ringNext       = '0;
      timerClearNext = 1'b1;
    end else if (timerStart) begin
      case (timerState)
        T_IDLE: begin
          timerNext     = T_RUN;
          timerLoadNext = 1'b1;
        end
        T_RUN:   timerNext = T_PAUSE;
        T_PAUSE: timerNext = T_RUN;
        default: timerNext = timerState;
      endcase
    end else if ((timerState == T_RUN) && watchBus.timerDone) begin
      timerNext = T_RING;
      ringNext  = '0;
    end else if ((timerState == T_RING) && watchBus.tick100Hz) begin
      if (ringCount == RING_LAST) begin
        timerNext      = T_IDLE;
        ringNext       = '0;
        timerClearNext = 1'b1;
      end else begin
        ringNext = ringCount + 1'b1;
      end
    end

    if ((swState == S_RUN) && watchBus.stopwatchWrap) begin
      swNext       = S_CLEAR;
      swClearNext  = 1'b1;
      nextSlotNext = '0;
      lapIndexNext = '0;
      lapFullNext  = 1'b0;
    end else if (swStart) begin
      swNext = (swState == S_RUN) ? S_STOP : S_RUN;
    end else if (swSplit) begin
      case (swState)
        S_RUN: begin
          if (!lapFullReg) begin
            lapStrobeNext = 1'b1;
            lapIndexNext  = nextSlot;
            nextSlotNext  = nextSlot + 1'b1;
            lapFullNext   = (nextSlot == LAP_LAST);
          end
        end
        S_STOP: begin
          swNext       = S_CLEAR;
          swClearNext  = 1'b1;
          nextSlotNext = '0;
          lapIndexNext = '0;
          lapFullNext  = 1'b0;
        end
        default: swNext = swState;
      endcase
    end
  end

  assign watchBus.mode           = modeReg;
  assign watchBus.timerLoad      = timerLoadReg;
  assign watchBus.timerClear     = timerClearReg;
  assign watchBus.timerRun       = (timerState == T_RUN);
  assign watchBus.ringSound      = (timerState == T_RING);
  assign watchBus.stopwatchRun   = (swState == S_RUN);
  assign watchBus.stopwatchClear = swClearReg;
  assign watchBus.lapStrobe      = lapStrobeReg;
  assign watchBus.lapIndex       = lapIndexReg;
  assign watchBus.lapFull        = lapFullReg;

endmodule

// File: tb/tb_watch_mode_controller.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_watch_mode_controller;

  localparam int LAP_DEPTH  = 10;
  localparam int RING_TICKS = 3000;

  localparam int TM_IDLE = 0, TM_RUN = 1, TM_PAUSE = 2, TM_RING = 3;
  localparam int SW_CLEAR = 0, SW_RUN = 1, SW_STOP = 2;

  typedef struct packed {
    logic [1:0] mode;
    logic       timerLoad;
    logic       timerClear;
    logic       timerRun;
    logic       stopwatchRun;
    logic       stopwatchClear;
    logic       lapStrobe;
    logic [3:0] lapIndex;
    logic       lapFull;
    logic       ringSound;
  } expectType;

  logic clockSignal = 1'b0;
  logic resetSignal = 1'b1;

  watch_mode_controller_if watchBus ();

  watch_mode_controller #(
    .LAP_DEPTH  (LAP_DEPTH),
    .RING_TICKS (RING_TICKS)
  ) dut (
    .clockSignal (clockSignal),
    .resetSignal (resetSignal),
    .watchBus    (watchBus)
  );

  always #5 clockSignal = ~clockSignal;

  expectType expectQueue[$];
  int checks   = 0;
  int failures = 0;

  bit lvMode = 0, lvStart = 0, lvSplit = 0;

  int mMode = 0, mTimer = TM_IDLE, mSw = SW_CLEAR;
  int mLapsTaken = 0, mShownSlot = 0, mRingTicks = 0;
  bit prevMode = 0, prevStart = 0, prevSplit = 0;

  task automatic modelStep(input bit rst, input bit tick, input bit done, input bit wrap,
                           output expectType e);
    bit eM, eSt, eSp, load, clr, swClr, strobe;
    load = 0; clr = 0; swClr = 0; strobe = 0;
    eM = lvMode && !prevMode;
    eSt = lvStart && !prevStart;
    eSp = lvSplit && !prevSplit;
    if (rst) begin
      mMode = 0; mTimer = TM_IDLE; mSw = SW_CLEAR;
      mLapsTaken = 0; mShownSlot = 0; mRingTicks = 0;
    end else begin
      if (mTimer == TM_RING && (eM || eSt || eSp)) begin
        mTimer = TM_IDLE; mRingTicks = 0; clr = 1;
        eM = 0; eSt = 0; eSp = 0;
      end else if (eM) begin
        mMode = (mMode + 1) % 4;
        eSt = 0; eSp = 0;
      end else if (eSp) begin
        eSt = 0;
      end
      if (mMode == 0 && eSp) begin
        mTimer = TM_IDLE; clr = 1;
      end else if (mMode == 0 && eSt) begin
        if (mTimer == TM_IDLE) begin mTimer = TM_RUN; load = 1; end
        else if (mTimer == TM_RUN) mTimer = TM_PAUSE;
        else if (mTimer == TM_PAUSE) mTimer = TM_RUN;
      end else if (mTimer == TM_RUN && done) begin
        mTimer = TM_RING; mRingTicks = 0;
      end else if (mTimer == TM_RING && tick) begin
        mRingTicks++;
        if (mRingTicks == RING_TICKS) begin mTimer = TM_IDLE; mRingTicks = 0; clr = 1; end
      end
      if (wrap && mSw == SW_RUN) begin
        mSw = SW_CLEAR; swClr = 1; mLapsTaken = 0; mShownSlot = 0;
      end else if (mMode == 1 && eSt) begin
        mSw = (mSw == SW_RUN) ? SW_STOP : SW_RUN;
      end else if (mMode == 1 && eSp) begin
        if (mSw == SW_RUN && mLapsTaken < LAP_DEPTH) begin
          strobe = 1; mShownSlot = mLapsTaken; mLapsTaken++;
        end else if (mSw == SW_STOP) begin
          mSw = SW_CLEAR; swClr = 1; mLapsTaken = 0; mShownSlot = 0;
        end
      end
    end
    prevMode = lvMode; prevStart = lvStart; prevSplit = lvSplit;
    e.mode           = 2'(mMode);
    e.timerLoad      = load;
    e.timerClear     = clr;
    e.timerRun       = (mTimer == TM_RUN);
    e.ringSound      = (mTimer == TM_RING);
    e.stopwatchRun   = (mSw == SW_RUN);
    e.stopwatchClear = swClr;
    e.lapStrobe      = strobe;
    e.lapIndex       = 4'(mShownSlot);
    e.lapFull        = (mLapsTaken == LAP_DEPTH);
  endtask

  task automatic drive(input bit rst, input bit tick, input bit done, input bit wrap);
    expectType e;
    @(negedge clockSignal);
    resetSignal             = rst;
    watchBus.modeInput      = lvMode;
    watchBus.startOrStop    = lvStart;
    watchBus.splitOrReset   = lvSplit;
    watchBus.tick100Hz      = tick;
    watchBus.timerDone      = done;
    watchBus.stopwatchWrap  = wrap;
    modelStep(rst, tick, done, wrap, e);
    expectQueue.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  // which: 0 mode, 1 start, 2 split
  task automatic press(input int which);
    if (which == 0) lvMode = 1; else if (which == 1) lvStart = 1; else lvSplit = 1;
    idle(2);
    lvMode = 0; lvStart = 0; lvSplit = 0;
    idle(2);
  endtask

  task automatic checkField(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  initial begin
    expectType e;
    forever begin
      @(posedge clockSignal);
      #1;
      if (expectQueue.size() > 0) begin
        e = expectQueue.pop_front();
        checkField("mode",           int'(watchBus.mode),           int'(e.mode));
        checkField("timerLoad",      int'(watchBus.timerLoad),      int'(e.timerLoad));
        checkField("timerClear",     int'(watchBus.timerClear),     int'(e.timerClear));
        checkField("timerRun",       int'(watchBus.timerRun),       int'(e.timerRun));
        checkField("ringSound",      int'(watchBus.ringSound),      int'(e.ringSound));
        checkField("stopwatchRun",   int'(watchBus.stopwatchRun),   int'(e.stopwatchRun));
        checkField("stopwatchClear", int'(watchBus.stopwatchClear), int'(e.stopwatchClear));
        checkField("lapStrobe",      int'(watchBus.lapStrobe),      int'(e.lapStrobe));
        checkField("lapIndex",       int'(watchBus.lapIndex),       int'(e.lapIndex));
        checkField("lapFull",        int'(watchBus.lapFull),        int'(e.lapFull));
      end
    end
  end

  initial begin
    watchBus.modeInput = 0; watchBus.startOrStop = 0; watchBus.splitOrReset = 0;
    watchBus.tick100Hz = 0; watchBus.timerDone = 0; watchBus.stopwatchWrap = 0;

    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 5; i++) press(0);
    for (int i = 0; i < 3; i++) press(0);

    press(1);
    press(1);
    press(1);
    drive(0, 0, 1, 0);
    idle(2);
    for (int i = 0; i < RING_TICKS; i++) drive(0, 1, 0, 0);
    idle(2);
    press(1);
    drive(0, 0, 1, 0);
    idle(2);
    press(0);

    lvMode = 1; lvStart = 1;
    idle(2);
    lvMode = 0; lvStart = 0;
    idle(2);

    press(1);
    for (int i = 0; i < LAP_DEPTH + 1; i++) press(2);
    press(1);
    press(2);

    press(1);
    lvSplit = 1;
    drive(0, 0, 0, 1);
    idle(1);
    lvSplit = 0;
    idle(2);

    for (int i = 0; i < 3; i++) press(0);
    press(1);
    lvStart = 1;
    idle(1);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    idle(3);
    lvStart = 0;
    idle(2);

    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(7) == 0) lvMode  = ~lvMode;
      if ($urandom_range(5) == 0) lvStart = ~lvStart;
      if ($urandom_range(5) == 0) lvSplit = ~lvSplit;
      drive($urandom_range(499) == 0,
            $urandom_range(3) == 0,
            $urandom_range(15) == 0,
            $urandom_range(63) == 0);
    end
    lvMode = 0; lvStart = 0; lvSplit = 0;
    idle(2);

    @(posedge clockSignal);
    #2;
    checks++;
    if (expectQueue.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions left, expected 0", expectQueue.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
